// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared state, T-state and arbitration constants for the memory bus controller
package mem_bus_pkg;

  // Controller states; one access walks T1..T4 in order
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_T4   = 3'd4;

  // Values reported on t_cycle
  localparam logic [1:0] TC_T1 = 2'd0;
  localparam logic [1:0] TC_T2 = 2'd1;
  localparam logic [1:0] TC_T3 = 2'd2;
  localparam logic [1:0] TC_T4 = 2'd3;

  // Arbitration modes
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - combinational one-hot arbiter, fixed priority or round-robin from a pointer
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int PTR_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [PTR_W-1:0]       i_ptr,
  input  logic                   i_rr,
  output logic [NUM_MASTERS-1:0] o_grant,
  output logic [PTR_W-1:0]       o_grant_idx,
  output logic                   o_valid
);

  int w_start;
  int w_dist;
  int w_best;

  // The requester closest to the search start (distance measured modulo NUM_MASTERS) wins;
  // fixed priority is simply a search that always starts at index 0.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_start     = i_rr ? int'(i_ptr) : 0;
    w_dist      = 0;
    w_best      = NUM_MASTERS;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (i_req[i]) begin
        w_dist = i - w_start;
        if (w_dist < 0) w_dist = w_dist + NUM_MASTERS;
        if (w_dist < w_best) begin
          w_best      = w_dist;
          o_grant     = '0;
          o_grant[i]  = 1'b1;
          o_grant_idx = PTR_W'(i);
        end
      end
    end
    o_valid = |i_req;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - multi-master memory bus controller with fixed 4-clock T1..T4 accesses
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int ARB_MODE    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS-1:0]        we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] wdata,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic [NUM_MASTERS-1:0]        done,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic [1:0]                    t_cycle,
  output logic                          busy
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [2:0]             r_state;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [PTR_W-1:0]       r_owner;
  logic [PTR_W-1:0]       r_ptr;
  logic                   r_we_q;
  logic [DATA_W-1:0]      r_rdata;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_mem_wdata;

  logic [NUM_MASTERS-1:0] w_arb_req;
  logic [PTR_W-1:0]       w_next_ptr;
  logic [PTR_W-1:0]       w_arb_ptr;
  logic [NUM_MASTERS-1:0] w_win;
  logic [PTR_W-1:0]       w_win_idx;
  logic                   w_win_valid;
  logic [ADDR_W-1:0]      w_sel_addr;
  logic [DATA_W-1:0]      w_sel_wdata;
  logic                   w_sel_we;

  // Pointer value the round-robin search uses once the current owner finishes
  assign w_next_ptr = (r_owner == PTR_W'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;

  // In T4 the owner is masked out and the search already starts past it, so the
  // back-to-back decision and the pointer update agree
  assign w_arb_req = (r_state == ST_T4) ? (req & ~r_gnt) : req;
  assign w_arb_ptr = (r_state == ST_T4) ? w_next_ptr : r_ptr;

  mem_bus_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .PTR_W       (PTR_W)
  ) u_arbiter (
    .i_req       (w_arb_req),
    .i_ptr       (w_arb_ptr),
    .i_rr        (ARB_MODE == ARB_RR),
    .o_grant     (w_win),
    .o_grant_idx (w_win_idx),
    .o_valid     (w_win_valid)
  );

  // Steer the winner's address, data and direction toward the latch
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_win[i]) begin
        w_sel_addr  = addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[i*DATA_W +: DATA_W];
        w_sel_we    = we[i];
      end
    end
  end

  // Access sequencer: grant and latch on entry to T1, capture read data leaving T3,
  // chain straight into the next access from T4 when another master is waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_we_q      <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_state     <= ST_T1;
            r_gnt       <= w_win;
            r_owner     <= w_win_idx;
            r_we_q      <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
          end
        end
        ST_T1: r_state <= ST_T2;
        ST_T2: r_state <= ST_T3;
        ST_T3: begin
          r_state <= ST_T4;
          if (!r_we_q) r_rdata <= mem_rdata;
        end
        ST_T4: begin
          r_ptr <= w_next_ptr;
          if (w_win_valid) begin
            r_state     <= ST_T1;
            r_gnt       <= w_win;
            r_owner     <= w_win_idx;
            r_we_q      <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
          end else begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // T-state report decoded from the state register
  always_comb begin
    case (r_state)
      ST_T1:   t_cycle = TC_T1;
      ST_T2:   t_cycle = TC_T2;
      ST_T3:   t_cycle = TC_T3;
      ST_T4:   t_cycle = TC_T4;
      default: t_cycle = TC_T1;
    endcase
  end

  // Strobes and done are decoded from state, so reset clears them without waiting for a clock
  assign gnt       = r_gnt;
  assign done      = (r_state == ST_T4) ? r_gnt : '0;
  assign mem_rd    = ((r_state == ST_T2) || (r_state == ST_T3)) && !r_we_q;
  assign mem_wr    = ((r_state == ST_T2) || (r_state == ST_T3)) && r_we_q;
  assign busy      = (r_state != ST_IDLE);
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - self-checking bench for mem_bus_ctrl in fixed-priority and round-robin builds
module tb_mem_bus_ctrl;

  typedef struct {
    int         idx;
    logic       wr;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;

  // Two masters, fixed priority
  logic [1:0]  req0, we0, gnt0, done0;
  logic [31:0] addr0;
  logic [15:0] wdata0;
  logic [7:0]  rdata0, mem_wdata0, mem_rdata0;
  logic [15:0] mem_addr0;
  logic        mem_rd0, mem_wr0, busy0;
  logic [1:0]  t_cycle0;

  // Four masters, round-robin
  logic [3:0]  req1, we1, gnt1, done1;
  logic [63:0] addr1;
  logic [31:0] wdata1;
  logic [7:0]  rdata1, mem_wdata1, mem_rdata1;
  logic [15:0] mem_addr1;
  logic        mem_rd1, mem_wr1, busy1;
  logic [1:0]  t_cycle1;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0_e, m1_e;
  logic [7:0] last_rd0 = 8'h00;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h83;
  endfunction

  assign mem_rdata0 = mem_f(mem_addr0);
  assign mem_rdata1 = mem_f(mem_addr1);

  mem_bus_ctrl #(.NUM_MASTERS(2), .ADDR_W(16), .DATA_W(8), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .gnt(gnt0), .done(done0), .rdata(rdata0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .mem_rd(mem_rd0), .mem_wr(mem_wr0), .t_cycle(t_cycle0), .busy(busy0)
  );

  mem_bus_ctrl #(.NUM_MASTERS(4), .ADDR_W(16), .DATA_W(8), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .gnt(gnt1), .done(done1), .rdata(rdata1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .mem_rd(mem_rd1), .mem_wr(mem_wr1), .t_cycle(t_cycle1), .busy(busy1)
  );

  // Scoreboard and bus invariants for the two-master instance
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (mem_rd0 && mem_wr0) begin errors++; $display("FAIL dut0_rd_wr_excl: rd=%b wr=%b, required not both", mem_rd0, mem_wr0); end
      checks++;
      if (!$onehot0(gnt0)) begin errors++; $display("FAIL dut0_gnt_onehot: gnt=%b, required at most one bit", gnt0); end
      if (|done0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL dut0_unexpected_done: done=%b, required no completion", done0);
        end else begin
          m0_e = q0.pop_front();
          if (done0 !== 2'(1 << m0_e.idx)) begin errors++; $display("FAIL dut0_done_owner: done=%b, required %b", done0, 2'(1 << m0_e.idx)); end
          checks++;
          if (mem_addr0 !== m0_e.a) begin errors++; $display("FAIL dut0_sb_addr: mem_addr=%h, required %h", mem_addr0, m0_e.a); end
          checks++;
          if (rdata0 !== m0_e.rd) begin errors++; $display("FAIL dut0_sb_rdata: rdata=%h, required %h", rdata0, m0_e.rd); end
          if (m0_e.wr) begin
            checks++;
            if (mem_wdata0 !== m0_e.wd) begin errors++; $display("FAIL dut0_sb_wdata: mem_wdata=%h, required %h", mem_wdata0, m0_e.wd); end
          end
        end
      end
    end
  end

  // Scoreboard and bus invariants for the four-master instance
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (mem_rd1 && mem_wr1) begin errors++; $display("FAIL dut1_rd_wr_excl: rd=%b wr=%b, required not both", mem_rd1, mem_wr1); end
      checks++;
      if (!$onehot0(gnt1)) begin errors++; $display("FAIL dut1_gnt_onehot: gnt=%b, required at most one bit", gnt1); end
      if (|done1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL dut1_unexpected_done: done=%b, required no completion", done1);
        end else begin
          m1_e = q1.pop_front();
          if (done1 !== 4'(1 << m1_e.idx)) begin errors++; $display("FAIL dut1_done_owner: done=%b, required %b", done1, 4'(1 << m1_e.idx)); end
          checks++;
          if (mem_addr1 !== m1_e.a) begin errors++; $display("FAIL dut1_sb_addr: mem_addr=%h, required %h", mem_addr1, m1_e.a); end
          checks++;
          if (rdata1 !== m1_e.rd) begin errors++; $display("FAIL dut1_sb_rdata: rdata=%h, required %h", rdata1, m1_e.rd); end
        end
      end
    end
  end

  task automatic test_reset();
    req0 = 2'b11; req1 = 4'b1111;
    #1;
    checks++;
    if ({gnt0, done0, rdata0, mem_addr0, mem_wdata0, mem_rd0, mem_wr0, t_cycle0, busy0} !== '0) begin
      errors++; $display("FAIL reset_dut0_outputs: got %h, required 0", {gnt0, done0, rdata0, mem_addr0, mem_wdata0, mem_rd0, mem_wr0, t_cycle0, busy0});
    end
    checks++;
    if ({gnt1, done1, rdata1, mem_addr1, mem_wdata1, mem_rd1, mem_wr1, t_cycle1, busy1} !== '0) begin
      errors++; $display("FAIL reset_dut1_outputs: got %h, required 0", {gnt1, done1, rdata1, mem_addr1, mem_wdata1, mem_rd1, mem_wr1, t_cycle1, busy1});
    end
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b0 || gnt0 !== 2'b00) begin errors++; $display("FAIL reset_held_idle: busy=%b gnt=%b, required 0 and 00", busy0, gnt0); end
    req0 = 2'b00; req1 = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_release_idle: busy0=%b busy1=%b, required 0", busy0, busy1); end
  endtask

  task automatic test_cpu_read();
    exp_t e;
    addr0[15:0] = 16'h1234; we0 = 2'b00; req0 = 2'b01;
    e = '{idx: 0, wr: 1'b0, a: 16'h1234, wd: 8'h00, rd: mem_f(16'h1234)};
    last_rd0 = e.rd;
    q0.push_back(e);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (t_cycle0 !== 2'(k)) begin errors++; $display("FAIL cpu_read_tcycle: t_cycle=%0d, required %0d", t_cycle0, k); end
      checks++;
      if (mem_rd0 !== (k == 1 || k == 2)) begin errors++; $display("FAIL cpu_read_mem_rd: k=%0d mem_rd=%b, required %b", k, mem_rd0, (k == 1 || k == 2)); end
      checks++;
      if (gnt0 !== 2'b01 || busy0 !== 1'b1) begin errors++; $display("FAIL cpu_read_gnt: gnt=%b busy=%b, required 01 and 1", gnt0, busy0); end
      checks++;
      if (done0 !== ((k == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL cpu_read_latency: k=%0d done=%b", k, done0); end
      if (k == 3) begin
        checks++;
        if (rdata0 !== 8'hA5) begin errors++; $display("FAIL cpu_read_rdata: rdata=%h, required a5", rdata0); end
        req0 = 2'b00;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b0 || gnt0 !== 2'b00) begin errors++; $display("FAIL cpu_read_idle: busy=%b gnt=%b, required 0 and 00", busy0, gnt0); end
  endtask

  task automatic test_dma_write();
    addr0[31:16] = 16'hFE00; wdata0[15:8] = 8'h3C; we0 = 2'b10; req0 = 2'b10;
    q0.push_back('{idx: 1, wr: 1'b1, a: 16'hFE00, wd: 8'h3C, rd: last_rd0});
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_wr0 !== (k == 1 || k == 2) || mem_rd0 !== 1'b0) begin
        errors++; $display("FAIL dma_write_strobes: k=%0d wr=%b rd=%b, required wr=%b rd=0", k, mem_wr0, mem_rd0, (k == 1 || k == 2));
      end
      checks++;
      if (mem_wdata0 !== 8'h3C || gnt0 !== 2'b10) begin errors++; $display("FAIL dma_write_latch: wdata=%h gnt=%b, required 3c and 10", mem_wdata0, gnt0); end
      if (k == 3) req0 = 2'b00;
    end
    @(posedge clk); #1;
    checks++;
    if (rdata0 !== 8'hA5 || busy0 !== 1'b0) begin errors++; $display("FAIL dma_write_rdata_kept: rdata=%h busy=%b, required a5 and 0", rdata0, busy0); end
  endtask

  task automatic test_back_to_back();
    addr0 = {16'h2222, 16'h1111}; we0 = 2'b00; req0 = 2'b11;
    q0.push_back('{idx: 0, wr: 1'b0, a: 16'h1111, wd: 8'h00, rd: mem_f(16'h1111)});
    q0.push_back('{idx: 1, wr: 1'b0, a: 16'h2222, wd: 8'h00, rd: mem_f(16'h2222)});
    q0.push_back('{idx: 0, wr: 1'b0, a: 16'h1111, wd: 8'h00, rd: mem_f(16'h1111)});
    last_rd0 = mem_f(16'h1111);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      checks++;
      if (gnt0 !== 2'(1 << ((k / 4) % 2)) || busy0 !== 1'b1) begin
        errors++; $display("FAIL b2b_fixed_order: k=%0d gnt=%b busy=%b, required %b and 1", k, gnt0, busy0, 2'(1 << ((k / 4) % 2)));
      end
      checks++;
      if (t_cycle0 !== 2'(k % 4)) begin errors++; $display("FAIL b2b_fixed_tcycle: k=%0d t_cycle=%0d, required %0d", k, t_cycle0, k % 4); end
      if (k == 11) req0 = 2'b00;
    end
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_fixed_idle: busy=%b, required 0", busy0); end
  endtask

  task automatic test_round_robin();
    we1 = 4'b0000;
    for (int m = 0; m < 4; m++) addr1[16*m +: 16] = 16'((m + 1) * 16'h1000 + m);
    for (int j = 0; j < 5; j++) begin
      q1.push_back('{idx: j % 4, wr: 1'b0, a: 16'(((j % 4) + 1) * 16'h1000 + (j % 4)), wd: 8'h00,
                     rd: mem_f(16'(((j % 4) + 1) * 16'h1000 + (j % 4)))});
    end
    req1 = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if (gnt1 !== 4'(1 << ((k / 4) % 4)) || busy1 !== 1'b1) begin
        errors++; $display("FAIL rr_order: k=%0d gnt=%b busy=%b, required %b and 1", k, gnt1, busy1, 4'(1 << ((k / 4) % 4)));
      end
      if (k == 19) req1 = 4'b0000;
    end
    @(posedge clk); #1;
    checks++;
    if (busy1 !== 1'b0 || gnt1 !== 4'b0000) begin errors++; $display("FAIL rr_idle: busy=%b gnt=%b, required 0 and 0000", busy1, gnt1); end
  endtask

  task automatic test_reset_mid();
    addr0[15:0] = 16'h4242; we0 = 2'b00; req0 = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (t_cycle0 !== 2'd1 || mem_rd0 !== 1'b1) begin errors++; $display("FAIL reset_mid_in_t2: t_cycle=%0d rd=%b, required 1 and 1", t_cycle0, mem_rd0); end
    rst = 1'b0; req0 = 2'b00;
    #1;
    checks++;
    if ({gnt0, done0, rdata0, mem_addr0, mem_wdata0, mem_rd0, mem_wr0, t_cycle0, busy0} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h, required 0", {gnt0, done0, rdata0, mem_addr0, mem_wdata0, mem_rd0, mem_wr0, t_cycle0, busy0});
    end
    @(posedge clk); #1;
    rst = 1'b1; last_rd0 = 8'h00;
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 2'b00) begin errors++; $display("FAIL reset_mid_no_done: busy=%b done=%b, required 0 and 00", busy0, done0); end
    req0 = 2'b01;
    q0.push_back('{idx: 0, wr: 1'b0, a: 16'h4242, wd: 8'h00, rd: mem_f(16'h4242)});
    last_rd0 = mem_f(16'h4242);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (done0 !== ((k == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL reset_mid_restart: k=%0d done=%b", k, done0); end
      if (k == 3) req0 = 2'b00;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addr_change();
    addr0[15:0] = 16'h0F0F; we0 = 2'b00; req0 = 2'b01;
    q0.push_back('{idx: 0, wr: 1'b0, a: 16'h0F0F, wd: 8'h00, rd: mem_f(16'h0F0F)});
    last_rd0 = mem_f(16'h0F0F);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_addr0 !== 16'h0F0F) begin errors++; $display("FAIL addr_change_hold: k=%0d mem_addr=%h, required 0f0f", k, mem_addr0); end
      if (k == 1) addr0[15:0] = 16'hBEEF;
      if (k == 3) req0 = 2'b00;
    end
    @(posedge clk); #1;
    checks++;
    if (rdata0 !== mem_f(16'h0F0F)) begin errors++; $display("FAIL addr_change_rdata: rdata=%h, required %h", rdata0, mem_f(16'h0F0F)); end
  endtask

  initial begin
    rst = 1'b0;
    req0 = '0; we0 = '0; addr0 = '0; wdata0 = '0;
    req1 = '0; we1 = '0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
    test_addr_change();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL scoreboard_drained: pending dut0=%0d dut1=%0d, required 0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
